// File: rtl/prbs_pkg.sv
// Shared PRBS9 constants, FSM states and counter width
// used by the pattern source and the BER checker.
package prbs_pkg;

  localparam int         PRBS_LEN    = 9;
  localparam int         PRBS_PERIOD = 511;
  localparam int         PRBS_TAP    = 4;
  localparam logic [8:0] PRBS_SEED   = 9'h1FF;
  localparam int         CNT_W_DEF   = 33;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // An all-zero seed would lock the LFSR up forever.
  function automatic logic [PRBS_LEN-1:0] seed_fix(
    input logic [PRBS_LEN-1:0] s
  );
    return (s == '0) ? PRBS_SEED : s;
  endfunction

endpackage

// File: rtl/prbs9_lfsr.sv
// PRBS9 generator (x^9 + x^5 + 1): seed load, enabled
// advance, lock-up guard; output is the MSB.
module prbs9_lfsr
  import prbs_pkg::*;
#(
  parameter logic [8:0] SEED = PRBS_SEED
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_adv,
  output logic o_out
);

  localparam logic [8:0] SEED_L = seed_fix(SEED);

  logic [8:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (i_load || (lfsr_q == '0)) begin
      lfsr_d = SEED_L;
    end else if (i_adv) begin
      lfsr_d = {lfsr_q[7:0],
                lfsr_q[8] ^ lfsr_q[PRBS_TAP]};
    end
  end

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      lfsr_q <= SEED_L;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign o_out = lfsr_q[8];

endmodule

// File: rtl/prbs9_tx.sv
// PRBS9 transmit pattern source with burst/continuous modes.
// Optional error injection: define PRBS9_TX_ERR_INJECT_EN.
module prbs9_tx
  import prbs_pkg::*;
#(
  parameter logic [8:0] SEED  = PRBS_SEED,
  parameter int         CNT_W = CNT_W_DEF,
  parameter int         INJ_W = 16
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [CNT_W-1:0] i_nbits,
  output logic             o_bit,
  output logic             o_valid,
  output logic             o_period,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_bits
`ifdef PRBS9_TX_ERR_INJECT_EN
  ,
  input  logic [INJ_W-1:0] i_inj_period,
  output logic [CNT_W-1:0] o_inj_count
`endif
);

  if (INJ_W < 1) begin : g_bad_inj_w
    $error("INJ_W must be positive");
  end

  state_e           state_q, state_d;
  logic             bit_q, bit_d;
  logic             valid_q, valid_d;
  logic             period_q, period_d;
  logic [CNT_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic [8:0]       pcnt_q, pcnt_d;
  logic             lfsr_out;
  logic             inj_flip;
  logic             load, adv, last;
  logic [CNT_W-1:0] bits_inc;

  assign load     = (state_q == IDLE) && i_start;
  assign adv      = (state_q == RUN) && i_valid;
  assign bits_inc = bits_q + CNT_W'(1);
  assign last     = (nbits_q != '0)
                 && (bits_inc == nbits_q);

  prbs9_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clock   (clock),
    .i_reset (i_reset),
    .i_load  (load),
    .i_adv   (adv),
    .o_out   (lfsr_out)
  );

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    valid_d  = 1'b0;
    period_d = 1'b0;
    bits_d   = bits_q;
    nbits_d  = nbits_q;
    pcnt_d   = pcnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RUN;
          bits_d  = '0;
          pcnt_d  = '0;
          nbits_d = i_nbits;
        end
      end
      RUN: begin
        if (i_valid) begin
          bit_d   = lfsr_out ^ inj_flip;
          valid_d = 1'b1;
          bits_d  = (&bits_q) ? bits_q : bits_inc;
          if (pcnt_q == 9'(PRBS_PERIOD - 1)) begin
            pcnt_d   = '0;
            period_d = 1'b1;
          end else begin
            pcnt_d = pcnt_q + 9'd1;
          end
          if (last) state_d = DONE;
        end
        if (i_stop) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      bit_q    <= 1'b0;
      valid_q  <= 1'b0;
      period_q <= 1'b0;
      bits_q   <= '0;
      nbits_q  <= '0;
      pcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      valid_q  <= valid_d;
      period_q <= period_d;
      bits_q   <= bits_d;
      nbits_q  <= nbits_d;
      pcnt_q   <= pcnt_d;
    end
  end

`ifdef PRBS9_TX_ERR_INJECT_EN
  logic [INJ_W-1:0] icnt_q, icnt_d;
  logic [CNT_W-1:0] inj_q, inj_d;

  // Down-counter marks every i_inj_period-th strobed bit.
  always_comb begin
    icnt_d   = icnt_q;
    inj_d    = inj_q;
    inj_flip = 1'b0;
    if (load) begin
      icnt_d = i_inj_period;
      inj_d  = '0;
    end else if (adv && (i_inj_period != '0)) begin
      if (icnt_q <= INJ_W'(1)) begin
        inj_flip = 1'b1;
        icnt_d   = i_inj_period;
        inj_d    = (&inj_q) ? inj_q : inj_q + CNT_W'(1);
      end else begin
        icnt_d = icnt_q - INJ_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      icnt_q <= '0;
      inj_q  <= '0;
    end else begin
      icnt_q <= icnt_d;
      inj_q  <= inj_d;
    end
  end

  assign o_inj_count = inj_q;
`else
  assign inj_flip = 1'b0;
`endif

  assign o_bit    = bit_q;
  assign o_valid  = valid_q;
  assign o_period = period_q;
  assign o_bits   = bits_q;
  assign o_busy   = (state_q == RUN);
  assign o_done   = (state_q == DONE);

endmodule

// File: tb/tb_prbs9_tx.sv
// Bench for prbs9_tx: sequence-level reference model,
// per-cycle compare, directed scenarios plus random traffic.
module tb_prbs9_tx;

  localparam int CW = 33;

  logic          clock   = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_start = 1'b0;
  logic          i_stop  = 1'b0;
  logic [CW-1:0] i_nbits = '0;
  logic          o_bit, o_valid, o_period;
  logic          o_busy, o_done;
  logic [CW-1:0] o_bits;
`ifdef PRBS9_TX_ERR_INJECT_EN
  logic [15:0]   i_inj_period = '0;
  logic [CW-1:0] o_inj_count;
`endif

  int checks = 0;
  int errors = 0;

  bit seq[511];
  bit obs[$];

  bit     armed = 0, m_run = 0, m_done = 0;
  longint m_bits = 0, m_n = 0, m_inj = 0, m_iper = 0;
  longint k;
  bit     flip;
  logic   e_bit = 0, e_valid = 0, e_period = 0;
  logic   e_busy = 0, e_done = 0;
  longint e_bits = 0, e_inj = 0;
  int     n_valid = 0, n_period = 0, n_done = 0;

  prbs9_tx dut (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_valid  (i_valid),
    .i_start  (i_start),
    .i_stop   (i_stop),
    .i_nbits  (i_nbits),
    .o_bit    (o_bit),
    .o_valid  (o_valid),
    .o_period (o_period),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_bits   (o_bits)
`ifdef PRBS9_TX_ERR_INJECT_EN
    ,
    .i_inj_period (i_inj_period),
    .o_inj_count  (o_inj_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Model: bit k of a run (1-based) is seq[(k-1) mod 511].
  always @(posedge clock) begin
    if (!i_reset) begin
      armed = 1; m_run = 0; m_done = 0;
      m_bits = 0; m_inj = 0;
      e_bit = 0; e_valid = 0; e_period = 0;
      e_busy = 0; e_done = 0; e_bits = 0; e_inj = 0;
    end else begin
      e_valid  = 0;
      e_period = 0;
      if (m_done) begin
        m_done = 0;
      end else if (!m_run) begin
        if (i_start) begin
          m_run = 1; m_bits = 0; m_inj = 0;
          m_n = longint'(i_nbits);
`ifdef PRBS9_TX_ERR_INJECT_EN
          m_iper = longint'(i_inj_period);
`else
          m_iper = 0;
`endif
        end
      end else begin
        if (i_valid) begin
          k    = m_bits + 1;
          flip = (m_iper != 0) && (k % m_iper == 0);
          e_bit    = seq[m_bits % 511] ^ flip;
          e_period = (k % 511 == 0);
          e_valid  = 1;
          if (flip) m_inj++;
          m_bits = k;
          if (m_n != 0 && m_bits == m_n) begin
            m_run = 0; m_done = 1;
          end
        end
        if (i_stop) begin
          m_run = 0; m_done = 1;
        end
      end
      e_busy = m_run;
      e_done = m_done;
      e_bits = m_bits;
      e_inj  = m_inj;
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      chk("o_valid",  64'(o_valid),  64'(e_valid));
      chk("o_bit",    64'(o_bit),    64'(e_bit));
      chk("o_period", 64'(o_period), 64'(e_period));
      chk("o_busy",   64'(o_busy),   64'(e_busy));
      chk("o_done",   64'(o_done),   64'(e_done));
      chk("o_bits",   64'(o_bits),   64'(e_bits));
`ifdef PRBS9_TX_ERR_INJECT_EN
      chk("o_inj_count", 64'(o_inj_count), 64'(e_inj));
`endif
      if (o_valid === 1'b1) begin
        n_valid++;
        obs.push_back(o_bit);
      end
      if (o_period === 1'b1) n_period++;
      if (o_done === 1'b1) n_done++;
    end
  end

  task automatic cyc(input bit v, input bit s,
                     input bit p, input logic [CW-1:0] n);
    @(negedge clock);
    #1;
    i_valid = v; i_start = s; i_stop = p; i_nbits = n;
  endtask

  task automatic strobes(input int n, input bit rnd);
    int got = 0;
    bit v;
    while (got < n) begin
      v = rnd ? bit'($urandom % 2) : 1'b1;
      cyc(v, 0, 0, '0);
      if (v) got++;
    end
  endtask

  task automatic clr();
    n_valid = 0; n_period = 0; n_done = 0;
    obs.delete();
  endtask

  initial begin
    int ones, ones2, diffs, badpos;
    logic [8:0] first9;

    for (int i = 0; i < 9; i++) seq[i] = 1'b1;
    for (int i = 9; i < 511; i++)
      seq[i] = seq[i-9] ^ seq[i-5];
    ones = 0;
    for (int i = 0; i < 511; i++) ones += int'(seq[i]);
    for (int i = 0; i < 9; i++) first9[8-i] = seq[i];
    chk("model_seed", 64'(first9), 64'h1FF);
    chk("model_bit10", 64'(seq[9]), 64'd0);
    chk("model_bit15", 64'(seq[14]), 64'd1);
    chk("model_ones", 64'(ones), 64'd256);

    // Reset and idle outputs
    repeat (3) cyc(0, 0, 0, '0);
    i_reset = 1'b1;
    cyc(0, 0, 0, '0);
    chk("rst_flags", 64'({o_bit, o_valid, o_period,
                          o_busy, o_done}), 64'd0);
    chk("rst_bits", 64'(o_bits), 64'd0);

    // Seed order and continuous periods
    clr();
    cyc(0, 1, 0, '0);
    strobes(10, 0);
    cyc(0, 0, 0, '0);
    first9 = '0;
    for (int i = 0; i < 9; i++) first9[8-i] = obs[i];
    chk("first9", 64'(first9), 64'h1FF);
    chk("bit10", 64'(obs[9]), 64'd0);
    strobes(1012, 1);
    cyc(0, 0, 0, '0);
    chk("cont_bits", 64'(o_bits), 64'd1022);
    chk("cont_periods", 64'(n_period), 64'd2);
    ones = 0; ones2 = 0;
    for (int i = 0; i < 511; i++) begin
      ones  += int'(obs[i]);
      ones2 += int'(obs[i+511]);
    end
    chk("ones_p1", 64'(ones), 64'd256);
    chk("ones_p2", 64'(ones2), 64'd256);
    cyc(0, 0, 1, '0);
    cyc(0, 0, 0, '0);
    chk("stop_done", 64'(n_done), 64'd1);

    // Burst of 20 with alternating strobe
    clr();
    cyc(0, 1, 0, CW'(20));
    for (int i = 0; i < 40; i++)
      cyc(bit'(i % 2 == 0), 0, 0, '0);
    repeat (3) cyc(0, 0, 0, '0);
    chk("burst_valids", 64'(n_valid), 64'd20);
    chk("burst_done", 64'(n_done), 64'd1);
    chk("burst_bits", 64'(o_bits), 64'd20);
    chk("burst_busy", 64'(o_busy), 64'd0);

    // Stop together with bit 37, then restart from seed
    clr();
    cyc(0, 1, 0, '0);
    strobes(36, 1);
    cyc(1, 0, 1, '0);
    repeat (2) cyc(0, 0, 0, '0);
    chk("stop_bits", 64'(o_bits), 64'd37);
    chk("stop_valids", 64'(n_valid), 64'd37);
    chk("stop_done1", 64'(n_done), 64'd1);
    clr();
    cyc(0, 1, 0, '0);
    strobes(9, 0);
    cyc(0, 0, 0, '0);
    first9 = '0;
    for (int i = 0; i < 9; i++) first9[8-i] = obs[i];
    chk("restart_seed", 64'(first9), 64'h1FF);
    cyc(0, 0, 1, '0);
    cyc(0, 0, 0, '0);

    // Reset at bit 100 of a burst
    cyc(0, 1, 0, CW'(200));
    strobes(99, 1);
    clr();
    @(negedge clock);
    #1;
    i_valid = 1'b1; i_reset = 1'b0;
    cyc(0, 0, 0, '0);
    chk("mid_rst_flags", 64'({o_bit, o_valid, o_period,
                              o_busy, o_done}), 64'd0);
    chk("mid_rst_bits", 64'(o_bits), 64'd0);
    i_reset = 1'b1;
    repeat (3) cyc(0, 0, 0, '0);
    chk("mid_rst_nodone", 64'(n_done), 64'd0);
    cyc(0, 1, 1, '0);
    cyc(0, 0, 0, '0);
    chk("start_wins", 64'(o_busy), 64'd1);
    strobes(5, 1);
    cyc(0, 0, 1, '0);
    cyc(0, 0, 0, '0);

`ifdef PRBS9_TX_ERR_INJECT_EN
    clr();
    i_inj_period = 16'd100;
    cyc(0, 1, 0, '0);
    strobes(1000, 1);
    cyc(0, 0, 0, '0);
    diffs = 0; badpos = 0;
    for (int i = 0; i < 1000; i++) begin
      if (obs[i] != seq[i % 511]) begin
        diffs++;
        if ((i + 1) % 100 != 0) badpos++;
      end
    end
    chk("inj_diffs", 64'(diffs), 64'd10);
    chk("inj_badpos", 64'(badpos), 64'd0);
    chk("inj_count", 64'(o_inj_count), 64'd10);
    chk("inj_periods", 64'(n_period), 64'd1);
    cyc(0, 0, 1, '0);
    cyc(0, 0, 0, '0);
    i_inj_period = 16'd7;
`else
    diffs = 0; badpos = 0;
`endif

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      cyc(bit'($urandom % 2),
          bit'($urandom % 20 == 0),
          bit'($urandom % 50 == 0),
          ($urandom % 4 == 0) ? CW'(0)
                              : CW'($urandom_range(1, 60)));
    end
    cyc(0, 0, 1, '0);
    repeat (3) cyc(0, 0, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
